// File: rtl/stream_vector_arbiter.sv
// Round-robin arbiter that hands the output to one requester for a whole N-element vector.
// Latency: one cycle from element acceptance to out_valid/out_data; one idle grant cycle between vectors.
// Backpressure: only the owner sees req_ready (mirrors its req_valid); all others are held off until the vector ends.
// Optional feature: define STREAM_ARB_TIMEOUT_EN to zero-pad a vector whose owner stalls for TIMEOUT cycles.
module stream_vector_arbiter #(
  parameter int BITS    = 8,
  parameter int N       = 3,
  parameter int R       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [R-1:0]               req_valid,
  input  logic [R-1:0][BITS-1:0]     req_data,
  output logic [R-1:0]               req_ready,
  output logic                       out_valid,
  output logic [BITS-1:0]            out_data,
  output logic                       vec_done,
  output logic [$clog2(R)-1:0]       vec_owner,
  output logic                       vec_abort,
  output logic                       busy
);

  localparam int OW = $clog2(R);
  localparam int CW = $clog2(N);

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, PAD = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [OW-1:0]     last_owner_q, last_owner_d;
  logic [OW-1:0]     vec_owner_q, vec_owner_d;
  logic              out_valid_q, out_valid_d;
  logic [BITS-1:0]   out_data_q, out_data_d;
  logic              vec_done_q, vec_done_d;
`ifdef STREAM_ARB_TIMEOUT_EN
  logic              vec_abort_q, vec_abort_d;
  logic [SW-1:0]     stall_q, stall_d;
`endif

  logic              grant_vld;
  logic [OW-1:0]     grant_idx;

  // Round-robin pick: first valid requester after the previous owner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= R; k++) begin
      if (!grant_vld && req_valid[(int'(last_owner_q) + k) % R]) begin
        grant_vld = 1'b1;
        grant_idx = OW'((int'(last_owner_q) + k) % R);
      end
    end
  end

  // Only the vector owner is ever accepted, and only while streaming.
  always_comb begin
    req_ready = '0;
    if (state_q == STREAM) begin
      req_ready[vec_owner_q] = req_valid[vec_owner_q];
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_owner_d = last_owner_q;
    vec_owner_d  = vec_owner_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    vec_done_d   = 1'b0;
`ifdef STREAM_ARB_TIMEOUT_EN
    vec_abort_d  = 1'b0;
    stall_d      = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          vec_owner_d = grant_idx;
          count_d     = '0;
          state_d     = STREAM;
`ifdef STREAM_ARB_TIMEOUT_EN
          stall_d     = '0;
`endif
        end
      end
      STREAM: begin
        if (req_valid[vec_owner_q]) begin
          out_valid_d = 1'b1;
          out_data_d  = req_data[vec_owner_q];
`ifdef STREAM_ARB_TIMEOUT_EN
          stall_d     = '0;
`endif
          if (count_q == CW'(N - 1)) begin
            count_d      = '0;
            vec_done_d   = 1'b1;
            last_owner_d = vec_owner_q;
            state_d      = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
`ifdef STREAM_ARB_TIMEOUT_EN
        else if (stall_q == SW'(TIMEOUT - 1)) begin
          stall_d = '0;
          state_d = PAD;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
`ifdef STREAM_ARB_TIMEOUT_EN
      PAD: begin
        // Fill the remainder of the vector with zeros, one per cycle.
        out_valid_d = 1'b1;
        out_data_d  = '0;
        if (count_q == CW'(N - 1)) begin
          count_d      = '0;
          vec_done_d   = 1'b1;
          vec_abort_d  = 1'b1;
          last_owner_d = vec_owner_q;
          state_d      = IDLE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset gives requester 0 first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_owner_q <= OW'(R - 1);
      vec_owner_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      vec_done_q   <= 1'b0;
`ifdef STREAM_ARB_TIMEOUT_EN
      vec_abort_q  <= 1'b0;
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_owner_q <= last_owner_d;
      vec_owner_q  <= vec_owner_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      vec_done_q   <= vec_done_d;
`ifdef STREAM_ARB_TIMEOUT_EN
      vec_abort_q  <= vec_abort_d;
      stall_q      <= stall_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign vec_done  = vec_done_q;
  assign vec_owner = vec_owner_q;
  assign busy      = (state_q != IDLE);
`ifdef STREAM_ARB_TIMEOUT_EN
  assign vec_abort = vec_abort_q;
`else
  assign vec_abort = 1'b0;
`endif

endmodule

// File: tb/tb_stream_vector_arbiter.sv
// Bench for stream_vector_arbiter: directed scenarios plus random traffic against a vector-level model.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// The model tracks who owns the output, how many elements are in the vector and the stall run.
module tb_stream_vector_arbiter;
  localparam int BITS    = 8;
  localparam int N       = 3;
  localparam int R       = 4;
  localparam int TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [R-1:0]           req_valid;
  logic [R-1:0][BITS-1:0] req_data;
  logic [R-1:0]           req_ready;
  logic                   out_valid;
  logic [BITS-1:0]        out_data;
  logic                   vec_done;
  logic [$clog2(R)-1:0]   vec_owner;
  logic                   vec_abort;
  logic                   busy;

  stream_vector_arbiter #(.BITS(BITS), .N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .vec_done(vec_done), .vec_owner(vec_owner), .vec_abort(vec_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: vector ownership and element counting.
  bit m_active, m_pad;
  int m_owner, m_last, m_cnt, m_stall;
  bit e_ov, e_done, e_abort;
  int e_od;

  // Observed-traffic captures for the directed scenarios.
  logic [BITS-1:0] cap_q[$];
  int              own_q[$];
  int              done_cnt, abort_cnt, abort_w_done;
  bit              rdy1_seen;

  function automatic void model_reset();
    m_active = 0; m_pad = 0; m_owner = 0; m_last = R - 1;
    m_cnt = 0; m_stall = 0;
    e_ov = 0; e_od = 0; e_done = 0; e_abort = 0;
  endfunction

  function automatic void model_step(input logic [R-1:0] v, input logic [R-1:0][BITS-1:0] d);
    bit ov = 0, dn = 0, ab = 0, found = 0;
    if (m_pad) begin
      ov = 1; e_od = 0; m_cnt++;
      if (m_cnt == N) begin dn = 1; ab = 1; m_pad = 0; m_last = m_owner; end
    end else if (m_active) begin
      if (v[m_owner]) begin
        ov = 1; e_od = int'(d[m_owner]); m_stall = 0; m_cnt++;
        if (m_cnt == N) begin dn = 1; m_active = 0; m_last = m_owner; end
      end
`ifdef STREAM_ARB_TIMEOUT_EN
      else begin
        m_stall++;
        if (m_stall == TIMEOUT) begin m_active = 0; m_pad = 1; m_stall = 0; end
      end
`endif
    end else begin
      for (int k = 1; k <= R; k++) begin
        int c = (m_last + k) % R;
        if (!found && v[c]) begin
          found = 1; m_owner = c; m_active = 1; m_cnt = 0; m_stall = 0;
        end
      end
    end
    e_ov = ov; e_done = dn; e_abort = ab;
  endfunction

  function automatic void clear_caps();
    cap_q.delete(); own_q.delete();
    done_cnt = 0; abort_cnt = 0; abort_w_done = 0; rdy1_seen = 0;
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model on the rising edge.
  task automatic run_cycle(input logic [R-1:0] v, input logic [R-1:0][BITS-1:0] d);
    logic [R-1:0] exp_rdy;
    req_valid = v;
    req_data  = d;
    #1;
    exp_rdy = '0;
    if (m_active && v[m_owner]) exp_rdy[m_owner] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_active || m_pad));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (e_ov) chk("out_data", 32'(out_data), e_od);
    chk("vec_done", 32'(vec_done), 32'(e_done));
    chk("vec_abort", 32'(vec_abort), 32'(e_abort));
    chk("vec_owner", 32'(vec_owner), m_owner);
    if (out_valid) cap_q.push_back(out_data);
    if (vec_done) begin done_cnt++; own_q.push_back(int'(vec_owner)); end
    if (vec_abort) begin abort_cnt++; if (vec_done) abort_w_done++; end
    if (req_ready[1]) rdy1_seen = 1;
    @(posedge clk);
    model_step(v, d);
    @(negedge clk);
  endtask

  // Reset is asserted between edges so its effect must show without a clock.
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_vec_done", 32'(vec_done), 0);
    chk("rst_vec_abort", 32'(vec_abort), 0);
    chk("rst_vec_owner", 32'(vec_owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [R-1:0][BITS-1:0] rand_data();
    logic [R-1:0][BITS-1:0] d;
    for (int i = 0; i < R; i++) d[i] = BITS'($urandom);
    return d;
  endfunction

  logic [BITS-1:0]        seq_tbl [3];
  logic [R-1:0][BITS-1:0] dd;
  int                     dens;

  initial begin
    seq_tbl = '{8'h11, 8'h22, 8'h33};
    reset = 1'b1; req_valid = '0; req_data = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single requester, three known elements.
    clear_caps();
    for (int c = 0; c < 5; c++) begin
      dd = '0;
      if (m_active && m_cnt < N) dd[0] = seq_tbl[m_cnt];
      run_cycle(4'b0001, dd);
    end
    chk("t1_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("t1_e0", 32'(cap_q[0]), 32'h11);
      chk("t1_e1", 32'(cap_q[1]), 32'h22);
      chk("t1_e2", 32'(cap_q[2]), 32'h33);
    end
    chk("t1_done", done_cnt, 1);
    if (own_q.size() > 0) chk("t1_owner", own_q[0], 0);

    // All requesters always valid: owners rotate 0,1,2,3,0.
    do_reset();
    clear_caps();
    for (int c = 0; c < 21; c++) run_cycle(4'b1111, rand_data());
    chk("t2_vectors", own_q.size(), 5);
    chk("t2_elems", cap_q.size(), 15);
    for (int i = 0; i < 5 && i < own_q.size(); i++) chk("t2_owner", own_q[i], i % R);

    // Owner 2 stalls mid-vector while requester 1 waits.
    do_reset();
    clear_caps();
    run_cycle(4'b0100, rand_data());
    run_cycle(4'b0100, rand_data());
    for (int c = 0; c < 5; c++) run_cycle(4'b0010, rand_data());
    run_cycle(4'b0110, rand_data());
    run_cycle(4'b0110, rand_data());
    run_cycle(4'b0010, rand_data());
    chk("t3_rdy1_held", 32'(rdy1_seen), 0);
    chk("t3_elems", cap_q.size(), 3);
    chk("t3_done", done_cnt, 1);
    if (own_q.size() > 0) chk("t3_owner", own_q[0], 2);

    // Partial vector discarded by reset; priority returns to requester 0.
    do_reset();
    clear_caps();
    for (int c = 0; c < 4; c++) run_cycle(4'b0010, rand_data());
    for (int c = 0; c < 3; c++) run_cycle(4'b0100, rand_data());
    chk("t4_owner_before", 32'(vec_owner), 2);
    do_reset();
    chk("t4_done_count", done_cnt, 1);
    run_cycle(4'b1111, rand_data());
    chk("t4_first_grant", 32'(vec_owner), 0);

`ifdef STREAM_ARB_TIMEOUT_EN
    // One element then silence: vector is padded with zeros and aborted.
    do_reset();
    clear_caps();
    dd = '0; dd[0] = 8'hAA;
    run_cycle(4'b0001, dd);
    run_cycle(4'b0001, dd);
    for (int c = 0; c < 20; c++) run_cycle(4'b0000, rand_data());
    chk("t5_elems", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("t5_e0", 32'(cap_q[0]), 32'hAA);
      chk("t5_pad1", 32'(cap_q[1]), 0);
      chk("t5_pad2", 32'(cap_q[2]), 0);
    end
    chk("t5_done", done_cnt, 1);
    chk("t5_abort_with_done", abort_w_done, 1);
`endif

    // Random traffic with varying request density and occasional resets.
    do_reset();
    dens = 50;
    for (int c = 0; c < 3000; c++) begin
      logic [R-1:0] v;
      if (c % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: dens = 3;
          1: dens = 50;
          default: dens = 90;
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        for (int i = 0; i < R; i++) v[i] = ($urandom_range(0, 99) < dens);
        run_cycle(v, rand_data());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
